// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap redirect, circular return-address stack and flush pulse.
// Optional build macro PC_MISALIGN_TRAP_EN turns jumps to targets not a multiple of INC into traps.
module pc_unit #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned INC       = 1,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned TRAP_VEC  = 1,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              enable,
    input  logic              select,
    input  logic              call,
    input  logic              ret,
    input  logic              trap,
    input  logic [ADDR_W-1:0] addrJump,
    output logic [ADDR_W-1:0] addrOut,
    output logic              flushOut,
    output logic              rasEmpty,
    output logic              rasFull,
    output logic              misalignOut
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              flush_q, flush_d;
    logic              mis_q, mis_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic              ras_we;
    logic [PTR_W-1:0]  ras_widx;
    logic [ADDR_W-1:0] ras_wdata;
    logic              misalign;

    assign pc_inc   = pc_q + ADDR_W'(INC);
    assign top_idx  = ptr_q - PTR_W'(1);
    assign rasEmpty = (cnt_q == '0);
    assign rasFull  = (cnt_q == CNT_W'(RAS_DEPTH));

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = ((32'(addrJump) % INC) != 0);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_q;
        flush_d   = 1'b0;
        mis_d     = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_widx  = ptr_q;
        ras_wdata = pc_inc;
        if (enable) begin
            if (trap) begin
                pc_d    = ADDR_W'(TRAP_VEC);
                flush_d = 1'b1;
            end else if (ret && !rasEmpty) begin
                pc_d    = ras_q[top_idx];
                flush_d = 1'b1;
                if (call && select) begin
                    // Swap: replace the popped top with our own return address.
                    ras_we   = 1'b1;
                    ras_widx = top_idx;
                end else begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (ret || select) begin
                flush_d = 1'b1;
                if (misalign) begin
                    pc_d  = ADDR_W'(TRAP_VEC);
                    mis_d = 1'b1;
                end else begin
                    pc_d = addrJump;
                    if (!ret && call) begin
                        // Full stack overwrites the oldest entry; count saturates.
                        ras_we = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                        if (!rasFull) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            pc_q    <= ADDR_W'(RESET_VEC);
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_q[ras_widx] <= ras_wdata;
    end

    assign addrOut     = pc_q;
    assign flushOut    = flush_q;
    assign misalignOut = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: default instance plus an INC=4 instance for target alignment.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       resetIn;
    logic       enable, select, call, ret, trap;
    logic [5:0] addrJump;
    logic [5:0] addrOut;
    logic       flushOut, rasEmpty, rasFull, misalignOut;

    logic       en4, sel4;
    logic       zero4 = 1'b0;
    logic [5:0] jump4;
    logic [5:0] addr4;
    logic       flush4, empty4, full4, mis4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk        (clk),
        .resetIn    (resetIn),
        .enable     (enable),
        .select     (select),
        .call       (call),
        .ret        (ret),
        .trap       (trap),
        .addrJump   (addrJump),
        .addrOut    (addrOut),
        .flushOut   (flushOut),
        .rasEmpty   (rasEmpty),
        .rasFull    (rasFull),
        .misalignOut(misalignOut)
    );

    pc_unit #(.INC(4)) u_dut4 (
        .clk        (clk),
        .resetIn    (resetIn),
        .enable     (en4),
        .select     (sel4),
        .call       (zero4),
        .ret        (zero4),
        .trap       (zero4),
        .addrJump   (jump4),
        .addrOut    (addr4),
        .flushOut   (flush4),
        .rasEmpty   (empty4),
        .rasFull    (full4),
        .misalignOut(mis4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic c, input logic r, input logic t,
                         input logic [5:0] j);
        select = s; call = c; ret = r; trap = t; addrJump = j;
    endtask

    initial begin
        resetIn = 1'b0; enable = 1'b1;
        en4 = 1'b0; sel4 = 1'b0; jump4 = '0;
        drive(0, 0, 0, 0, 6'd0);
        #3;
        check_eq("rst_addr", addrOut, 0);
        check_eq("rst_flush", flushOut, 0);
        check_eq("rst_empty", rasEmpty, 1);
        check_eq("rst_full", rasFull, 0);
        check_eq("rst_mis", misalignOut, 0);
        #9 resetIn = 1'b1;

        step(); check_eq("seq1", addrOut, 1);
        step(); check_eq("seq2", addrOut, 2);
        step(); check_eq("seq3", addrOut, 3);
        check_eq("seq_flush", flushOut, 0);
        check_eq("seq_empty", rasEmpty, 1);
        step(); step(); check_eq("seq5", addrOut, 5);

        // Call from 5 to 20, then return to 6.
        drive(1, 1, 0, 0, 6'd20);
        step(); check_eq("call_addr", addrOut, 20);
        check_eq("call_flush", flushOut, 1);
        check_eq("call_empty", rasEmpty, 0);
        drive(0, 0, 1, 0, 6'd0);
        step(); check_eq("ret_addr", addrOut, 6);
        check_eq("ret_flush", flushOut, 1);
        check_eq("ret_empty", rasEmpty, 1);
        drive(0, 0, 0, 0, 6'd0);
        step(); check_eq("after_ret", addrOut, 7);
        check_eq("after_ret_flush", flushOut, 0);

        // Trap beats select; RAS untouched.
        drive(1, 1, 0, 1, 6'd30);
        step(); check_eq("trap_addr", addrOut, 1);
        check_eq("trap_flush", flushOut, 1);
        check_eq("trap_empty", rasEmpty, 1);

        // Five calls push 2..6; the first (2) is overwritten.
        for (int i = 2; i <= 6; i++) begin
            drive(1, 1, 0, 0, 6'(i));
            step();
        end
        check_eq("calls_addr", addrOut, 6);
        check_eq("calls_full", rasFull, 1);
        for (int i = 6; i >= 3; i--) begin
            drive(0, 0, 1, 0, 6'd0);
            step(); check_eq("pop", addrOut, 32'(i));
        end
        check_eq("pop_empty", rasEmpty, 1);
        check_eq("pop_notfull", rasFull, 0);
        drive(0, 0, 1, 0, 6'd9);
        step(); check_eq("ret_empty_jump", addrOut, 9);
        check_eq("ret_empty_flush", flushOut, 1);

        // Swap: call 9->40 pushes 10; ret+call+select returns 10 and leaves 41 on top.
        drive(1, 1, 0, 0, 6'd40);
        step(); check_eq("swap_call", addrOut, 40);
        drive(1, 1, 1, 0, 6'd50);
        step(); check_eq("swap_addr", addrOut, 10);
        check_eq("swap_empty", rasEmpty, 0);
        drive(0, 0, 1, 0, 6'd0);
        step(); check_eq("swap_pop", addrOut, 41);
        check_eq("swap_pop_empty", rasEmpty, 1);

        // Hold with enable low ignores everything.
        enable = 1'b0;
        drive(1, 1, 0, 1, 6'd12);
        step(); check_eq("hold_addr", addrOut, 41);
        check_eq("hold_flush", flushOut, 0);
        step(); check_eq("hold_addr2", addrOut, 41);
        enable = 1'b1;

        // Wrap at 63.
        drive(1, 0, 0, 0, 6'd63);
        step(); check_eq("jump63", addrOut, 63);
        drive(0, 0, 0, 0, 6'd0);
        step(); check_eq("wrap", addrOut, 0);
        check_eq("wrap_flush", flushOut, 0);
        step(); step(); check_eq("post_wrap", addrOut, 2);

        // Asynchronous reset between edges.
        #3 resetIn = 1'b0;
        #1 check_eq("async_rst", addrOut, 0);
        check_eq("async_rst_flush", flushOut, 0);
        #1 resetIn = 1'b1;
        step(); check_eq("after_async", addrOut, 1);

        // INC=4 instance: target 6 is not a multiple of 4.
        en4 = 1'b1; sel4 = 1'b1; jump4 = 6'd6;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("mis_addr", addr4, 1);
        check_eq("mis_flag", mis4, 1);
`else
        check_eq("mis_addr", addr4, 6);
        check_eq("mis_flag", mis4, 0);
`endif
        check_eq("mis_flush", flush4, 1);
        sel4 = 1'b0;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("inc4_seq", addr4, 5);
`else
        check_eq("inc4_seq", addr4, 10);
`endif
        check_eq("mis_clear", mis4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
